// File: rtl/satatx_framer_if.sv
// satatx_framer_if: payload-in and primitive-stream-out handshake bundle for the SATA TX framer
// Signals:
//   S_AXIS_*  32-bit payload stream (TVALID/TREADY/TDATA/TLAST) plus TABORT
//   M_AXIS_*  33-bit word/primitive stream, bit 32 flags a primitive
// Modports: master = framer side, slave = environment side.
interface satatx_framer_if;
    logic        S_AXIS_TVALID;
    logic        S_AXIS_TREADY;
    logic [31:0] S_AXIS_TDATA;
    logic        S_AXIS_TLAST;
    logic        S_AXIS_TABORT;
    logic        M_AXIS_TVALID;
    logic        M_AXIS_TREADY;
    logic [32:0] M_AXIS_TDATA;
    modport master (
        input  S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TLAST, S_AXIS_TABORT, M_AXIS_TREADY,
        output S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA
    );
    modport slave (
        output S_AXIS_TVALID, S_AXIS_TDATA, S_AXIS_TLAST, S_AXIS_TABORT, M_AXIS_TREADY,
        input  S_AXIS_TREADY, M_AXIS_TVALID, M_AXIS_TDATA
    );
endinterface

// File: rtl/satatx_framer.sv
// satatx_framer: wraps payload frames as SOF, data, EOF, WTRM with HOLD on underflow and SYNC when idle
// Ports:
//   S_AXI_ACLK    clock, rising edge
//   S_AXI_ARESET  synchronous active-high reset
//   bus           satatx_framer_if.master: payload stream in, 33-bit primitive/word stream out
module satatx_framer #(
    parameter int P_MINIDLE = 2
) (
    input logic              S_AXI_ACLK,
    input logic              S_AXI_ARESET,
    satatx_framer_if.master  bus
);
    localparam logic [32:0] P_SOF  = 33'h1_7cb5_3737;
    localparam logic [32:0] P_EOF  = 33'h1_7cb5_d5d5;
    localparam logic [32:0] P_WTRM = 33'h1_7cb5_5858;
    localparam logic [32:0] P_SYNC = 33'h1_7c95_b5b5;
    localparam logic [32:0] P_HOLD = 33'h1_7caa_d5d5;
    localparam logic [3:0]  P_CNT  = 4'(P_MINIDLE);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_EOF, S_WTRM} state_t;

    state_t      r_state, w_state;
    logic [3:0]  r_cnt, w_cnt;
    logic        r_valid;
    logic [32:0] r_data, w_data;
    logic        w_adv;

    assign w_adv             = !r_valid || bus.M_AXIS_TREADY;
    assign bus.M_AXIS_TVALID = r_valid;
    assign bus.M_AXIS_TDATA  = r_data;
    assign bus.S_AXIS_TREADY = !S_AXI_ARESET && bus.M_AXIS_TREADY && r_state == S_DATA && !bus.S_AXIS_TABORT;

    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_data  = r_data;
        case (r_state)
            S_IDLE: begin
                if (r_cnt == 4'd0 && bus.S_AXIS_TVALID) begin
                    w_data  = P_SOF;
                    w_state = S_DATA;
                end else begin
                    w_data = P_SYNC;
                    w_cnt  = (r_cnt != 4'd0) ? r_cnt - 4'd1 : r_cnt;
                end
            end
            S_DATA: begin
                if (bus.S_AXIS_TABORT) begin
                    w_data  = P_WTRM;
                    w_state = S_IDLE;
                    w_cnt   = P_CNT;
                end else if (bus.S_AXIS_TVALID) begin
                    w_data  = {1'b0, bus.S_AXIS_TDATA};
                    w_state = bus.S_AXIS_TLAST ? S_EOF : S_DATA;
                end else begin
                    w_data = P_HOLD;
                end
            end
            S_EOF: begin
                // an abort here drops the EOF so the far end sees WTRM alone and flags the frame
                w_data  = bus.S_AXIS_TABORT ? P_WTRM : P_EOF;
                w_state = bus.S_AXIS_TABORT ? S_IDLE : S_WTRM;
                w_cnt   = bus.S_AXIS_TABORT ? P_CNT : r_cnt;
            end
            default: begin
                w_data  = P_WTRM;
                w_state = S_IDLE;
                w_cnt   = P_CNT;
            end
        endcase
    end

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            r_state <= S_IDLE;
            r_cnt   <= P_CNT;
            r_valid <= 1'b0;
            r_data  <= P_SYNC;
        end else if (w_adv) begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_valid <= 1'b1;
            r_data  <= w_data;
        end
    end
endmodule
